tdm_demux8: RTL and testbench

Receive end of the 8-channel single-line link. The block accepts one serial bit per slot strobe and tracks the slot index with an internal 3-bit channel counter, where channel 0 is marked by a frame sync. It assembles the 8 bits of a frame and publishes them as a parallel word with a one-cycle valid pulse. It sits behind the channel multiplexer stage and provides the clocked, frame-aligned replacement for a purely select-driven demultiplexer.

---
 rtl/tdm_demux8.sv | 98 +++++++++
 tb/tb_tdm_demux8.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// Receive side of the 8-channel single-line TDM link: tracks the slot index from
// the frame sync, assembles 8 serial bits and publishes them as one parallel word.
module tdm_demux8 #(
  parameter bit          STRICT_SYNC = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLine,
  input  logic             iEn,
  input  logic             iSync,
  output logic [7:0]       oData,
  output logic             oValid,
  output logic [2:0]       oSel,
  output logic             oLock,
  output logic             oErr,
  output logic [CNT_W-1:0] oFrames
);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state_q;
  logic [2:0]         sel_q;
  logic [6:0]         shadow_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               err_q;
  logic [CNT_W-1:0]   frames_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (iEn) begin
        unique case (state_q)
          HUNT: begin
            if (iSync) begin
              shadow_q[0] <= iLine;
              sel_q       <= 3'd1;
              state_q     <= RECV;
            end
          end
          RECV: begin
            if (iSync) begin
              // A sync anywhere but channel 0 aborts the partial frame and
              // restarts alignment on this very slot.
              if (sel_q != 3'd0) begin
                err_q <= 1'b1;
              end
              shadow_q[0] <= iLine;
              sel_q       <= 3'd1;
            end else if (sel_q == 3'd0) begin
              if (STRICT_SYNC) begin
                err_q   <= 1'b1;
                sel_q   <= '0;
                state_q <= HUNT;
              end else begin
                shadow_q[0] <= iLine;
                sel_q       <= 3'd1;
              end
            end else if (sel_q == 3'd7) begin
              data_q   <= {iLine, shadow_q};
              valid_q  <= 1'b1;
              frames_q <= frames_q + CNT_W'(1);
              sel_q    <= '0;
            end else begin
              shadow_q[sel_q] <= iLine;
              sel_q           <= sel_q + 3'd1;
            end
          end
          default: begin
            state_q <= HUNT;
            sel_q   <= '0;
          end
        endcase
      end
    end
  end

  assign oData   = data_q;
  assign oValid  = valid_q;
  assign oSel    = sel_q;
  assign oLock   = (state_q == RECV);
  assign oErr    = err_q;
  assign oFrames = frames_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: strict and free-running instances side by side, checked
// against a slot-level reference model of the link framing rules.
module tb_tdm_demux8;

  logic iClk, iRst, iLine, iEn, iSync;
  logic [7:0] d_data   [2];
  logic       d_valid  [2];
  logic [2:0] d_sel    [2];
  logic       d_lock   [2];
  logic       d_err    [2];
  logic [7:0] d_frames [2];

  int unsigned tests  = 0;
  int unsigned failed = 0;

  // index 0: STRICT_SYNC=1, index 1: STRICT_SYNC=0
  tdm_demux8 #(.STRICT_SYNC(1'b1), .CNT_W(8)) u_strict (
    .iClk(iClk), .iRst(iRst), .iLine(iLine), .iEn(iEn), .iSync(iSync),
    .oData(d_data[0]), .oValid(d_valid[0]), .oSel(d_sel[0]), .oLock(d_lock[0]),
    .oErr(d_err[0]), .oFrames(d_frames[0]));

  tdm_demux8 #(.STRICT_SYNC(1'b0), .CNT_W(8)) u_free (
    .iClk(iClk), .iRst(iRst), .iLine(iLine), .iEn(iEn), .iSync(iSync),
    .oData(d_data[1]), .oValid(d_valid[1]), .oSel(d_sel[1]), .oLock(d_lock[1]),
    .oErr(d_err[1]), .oFrames(d_frames[1]));

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference model: a frame is the list of bits received since the last sync.
  bit          m_lock   [2];
  int unsigned m_cnt    [2];
  bit   [7:0]  m_bits   [2];
  bit   [7:0]  m_data   [2];
  int unsigned m_frames [2];
  bit          m_valid  [2];
  bit          m_err    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int i, input bit strict, input bit rst, input bit en,
                       input bit line, input bit sync);
    m_valid[i] = 1'b0;
    m_err[i]   = 1'b0;
    if (rst) begin
      m_lock[i] = 1'b0; m_cnt[i] = 0; m_bits[i] = '0;
      m_data[i] = '0;   m_frames[i] = 0;
    end else if (en) begin
      if (!m_lock[i]) begin
        if (sync) begin
          m_lock[i] = 1'b1; m_bits[i] = '0; m_bits[i][0] = line; m_cnt[i] = 1;
        end
      end else if (sync) begin
        if (m_cnt[i] != 0) m_err[i] = 1'b1;
        m_bits[i] = '0; m_bits[i][0] = line; m_cnt[i] = 1;
      end else if (m_cnt[i] == 0) begin
        if (strict) begin
          m_err[i] = 1'b1; m_lock[i] = 1'b0;
        end else begin
          m_bits[i] = '0; m_bits[i][0] = line; m_cnt[i] = 1;
        end
      end else begin
        m_bits[i][m_cnt[i]] = line;
        m_cnt[i]++;
        if (m_cnt[i] == 8) begin
          m_data[i]  = m_bits[i];
          m_valid[i] = 1'b1;
          m_frames[i] = (m_frames[i] + 1) % 256;
          m_cnt[i]   = 0;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit line, input bit sync);
    iRst = rst; iEn = en; iLine = line; iSync = sync;
    @(posedge iClk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model(i, (i == 0), rst, en, line, sync);
      chk($sformatf("data%0d", i),   d_data[i],   m_data[i]);
      chk($sformatf("valid%0d", i),  d_valid[i],  m_valid[i]);
      chk($sformatf("sel%0d", i),    d_sel[i],    m_lock[i] ? m_cnt[i] : 0);
      chk($sformatf("lock%0d", i),   d_lock[i],   m_lock[i]);
      chk($sformatf("err%0d", i),    d_err[i],    m_err[i]);
      chk($sformatf("frames%0d", i), d_frames[i], m_frames[i]);
    end
  endtask

  task automatic frame(input logic [7:0] bits, input int unsigned maxgap);
    for (int c = 0; c < 8; c++) begin
      int unsigned gap = (maxgap == 0) ? 0 : $urandom_range(maxgap);
      repeat (gap) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      step(1'b0, 1'b1, bits[c], (c == 0));
    end
  endtask

  initial begin
    logic [7:0] pat;
    iRst = 1'b1; iEn = 1'b0; iLine = 1'b0; iSync = 1'b0;

    // Reset, then lock on 1,0,1,1,0,0,1,0
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_data", d_data[0], 8'h00);
    chk("rst_lock", d_lock[0], 1'b0);
    pat = 8'b0100_1101;
    frame(pat, 0);
    chk("lock_4d", d_data[0], 8'h4D);
    chk("lock_frames", d_frames[0], 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("valid_1cyc", d_valid[0], 1'b0);

    // Same frame with random idle gaps
    frame(pat, 3);
    chk("gap_4d", d_data[1], 8'h4D);

    // Early sync at channel 4, resync slot begins an all-ones frame
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c < 4; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("early_err", d_err[0], 1'b1);
    for (int c = 1; c < 8; c++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("early_ff", d_data[0], 8'hFF);
    chk("early_frames", d_frames[0], 8'd3);

    // Missing sync on channel 0, then a clean all-zeros frame
    frame(8'hA5, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("miss_err_strict", d_err[0], 1'b1);
    chk("miss_lock_free", d_lock[1], 1'b1);
    for (int c = 1; c < 8; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("miss_strict_held", d_data[0], 8'hA5);
    frame(8'h00, 0);
    chk("miss_zero", d_data[0], 8'h00);

    // Reset at channel 5
    frame(8'h3C, 0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1, (c == 0));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_data", d_data[0], 8'h00);
    chk("midrst_sel", d_sel[0], 3'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Random slot stream with stray syncs
    for (int n = 0; n < 400; n++)
      step(1'b0, ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(5) == 0));

    // 256 frames wrap the counter
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      frame(8'($urandom), 1);
      if (f == 254) chk("wrap_255", d_frames[0], 8'd255);
    end
    chk("wrap_0", d_frames[0], 8'd0);
    chk("wrap_0_free", d_frames[1], 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
